// File: rtl/mem_copy_engine.sv
// Source-to-destination word copy through a small backpressured FIFO, with
// optional reversal and saturating bias add; destination is read out sequentially.
module mem_copy_engine #(
  parameter  int DATA_W     = 8,
  parameter  int DEPTH      = 16,
  parameter  int FIFO_DEPTH = 4,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] bias,
  input  logic              hold,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              load_full,
  output logic              err
);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  logic [DATA_W-1:0] src_mem  [DEPTH];
  logic [DATA_W-1:0] dst_mem  [DEPTH];
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  state_t            state;
  logic [ADDR_W:0]   wr_ptr, len_q, rd_cnt, last_len;
  logic [ADDR_W-1:0] rd_ptr, dst_ptr;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] bias_q, src_q;
  logic              src_vld;
  logic [FAW-1:0]    f_wp, f_rp;
  logic [FAW:0]      fifo_cnt;

  logic              src_we, issue, push, pop;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W:0]   start_len;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] head, wdata;

  assign load_full = (wr_ptr == DEPTH_L);
  assign src_we    = wr_en && (state == IDLE) && !start && !load_full;
  assign start_len = (len == '0 || len > DEPTH_L) ? DEPTH_L : len;

  // In-flight read counts against FIFO space so a push can never find it full.
  assign issue    = (state == RUN) &&
                    ((fifo_cnt + (FAW+1)'(src_vld)) < (FAW+1)'(FIFO_DEPTH));
  assign src_addr = mode_q[0] ? ADDR_W'(len_q - ONE_L - rd_cnt) : ADDR_W'(rd_cnt);
  assign push     = src_vld;
  assign pop      = (fifo_cnt != '0) && !hold;

  assign head  = fifo_mem[f_rp];
  assign sum   = {1'b0, head} + {1'b0, bias_q};
  assign wdata = !mode_q[1] ? head : (sum[DATA_W] ? '1 : sum[DATA_W-1:0]);

  // Storage arrays carry no reset.
  always_ff @(posedge clk) begin
    if (src_we) src_mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    if (issue)  src_q <= src_mem[src_addr];
    if (push)   fifo_mem[f_wp] <= src_q;
    if (pop && !rst) dst_mem[dst_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_len <= DEPTH_L;
      len_q    <= DEPTH_L;
      mode_q   <= '0;
      bias_q   <= '0;
      rd_cnt   <= '0;
      dst_ptr  <= '0;
      src_vld  <= 1'b0;
      f_wp     <= '0;
      f_rp     <= '0;
      fifo_cnt <= '0;
    end else begin
      if (src_we) wr_ptr <= wr_ptr + ONE_L;
      if ((start || wr_en) && state != IDLE) err <= 1'b1;
      if (start && wr_en && state == IDLE)   err <= 1'b1;

      src_vld <= issue;
      if (issue) rd_cnt <= rd_cnt + ONE_L;
      if (push)  f_wp <= f_wp + FAW'(1);
      if (pop) begin
        f_rp    <= f_rp + FAW'(1);
        dst_ptr <= dst_ptr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (FAW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (FAW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase

      rd_valid <= 1'b0;
      if (state == IDLE && rd_en) begin
        rd_data  <= dst_mem[rd_ptr];
        rd_valid <= 1'b1;
        rd_ptr   <= ({1'b0, rd_ptr} == last_len - ONE_L) ? '0 : rd_ptr + ADDR_W'(1);
      end

      case (state)
        IDLE: if (start) begin
          state   <= RUN;
          busy    <= 1'b1;
          len_q   <= start_len;
          mode_q  <= mode;
          bias_q  <= bias;
          rd_cnt  <= '0;
          dst_ptr <= '0;
          rd_ptr  <= '0;
        end
        RUN:   if (issue && rd_cnt == len_q - ONE_L) state <= FLUSH;
        FLUSH: if (fifo_cnt == '0 && !src_vld) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          wr_ptr   <= '0;
          last_len <= len_q;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: a reference model fills the expected
// destination, readout expectations are queued at rd_en and popped on rd_valid.
module tb_mem_copy_engine;
  logic       clk = 1'b0;
  logic       rst, wr_en, start, hold, rd_en;
  logic [7:0] wr_data, bias, rd_data;
  logic [4:0] len;
  logic [1:0] mode;
  logic       rd_valid, busy, done, load_full, err;

  mem_copy_engine #(.DATA_W(8), .DEPTH(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .start(start),
    .len(len), .mode(mode), .bias(bias), .hold(hold), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .load_full(load_full), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [7:0] pat [16];
  logic [7:0] src_m [16];
  logic [7:0] dst_m [16];
  logic [7:0] sb [$];
  int ptr_m = 0, last_len_m = 16, max_cnt = 0, lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid) begin
      if (sb.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else                chk("rd_data", {24'd0, rd_data}, {24'd0, sb.pop_front()});
    end
    if (int'(dut.fifo_cnt) > max_cnt) max_cnt = int'(dut.fifo_cnt);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_all();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = pat[i]; src_m[i] = pat[i];
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Runs one transfer; hold is high at edges E(hf+1)..E(ht), inj injects
  // start/wr_en/rd_en at edge E(inj+1). Returns edges from E0 to done.
  task automatic run(input int l, input logic [1:0] m, input logic [7:0] b,
                     input int hf, input int ht, input int inj, output int n);
    int nn, idx, s;
    nn = (l == 0 || l > 16) ? 16 : l;
    start = 1'b1; len = 5'(l); mode = m; bias = b;
    tick();
    start = 1'b0;
    ptr_m = 0;
    chk("busy_rise", {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 200) begin
      hold  = (n >= hf && n < ht);
      start = (n == inj); wr_en = (n == inj); rd_en = (n == inj);
      if (inj >= 0 && n == inj + 1) begin
        chk("rdv_busy", {31'd0, rd_valid}, 32'd0);
        chk("err_run", {31'd0, err}, 32'd1);
      end
      tick();
      n++;
    end
    hold = 1'b0; start = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    for (int j = 0; j < nn; j++) begin
      idx = m[0] ? nn - 1 - j : j;
      s = int'(src_m[idx]) + (m[1] ? int'(b) : 0);
      dst_m[j] = (s > 255) ? 8'd255 : 8'(s);
    end
    last_len_m = nn;
    tick();
    chk("busy_fall", {31'd0, busy}, 32'd0);
    chk("done_fall", {31'd0, done}, 32'd0);
  endtask

  task automatic read_n(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      rd_en = 1'b1;
      sb.push_back(dst_m[ptr_m]);
      ptr_m = (ptr_m == last_len_m - 1) ? 0 : ptr_m + 1;
      tick();
    end
    rd_en = 1'b0;
    tick();
    chk("sb_drained", sb.size(), 32'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; wr_en = 0; start = 0; hold = 0; rd_en = 0;
    wr_data = 0; bias = 0; len = 0; mode = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_load_full", {31'd0, load_full}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    pat = '{8'd4, 8'd14, 8'd24, 8'd42, 8'd141, 8'd243, 8'd41, 8'd134,
            8'd204, 8'd124, 8'd104, 8'd24, 8'd34, 8'd74, 8'd84, 8'd95};

    // full copy, len=0 means DEPTH; readout wraps back to first word
    load_all();
    chk("load_full", {31'd0, load_full}, 32'd1);
    run(0, 2'b00, 8'd0, -1, -1, -1, lat);
    chk("lat_16", lat, 32'd19);
    chk("wr_ptr_clr", {31'd0, load_full}, 32'd0);
    read_n(17);

    // reversed 5-word copy
    load_all();
    run(5, 2'b01, 8'd0, -1, -1, -1, lat);
    chk("lat_5rev", lat, 32'd8);
    read_n(7);

    // saturating bias
    load_all();
    run(0, 2'b10, 8'd20, -1, -1, -1, lat);
    chk("lat_bias", lat, 32'd19);
    chk("bias_sat", {24'd0, dst_m[5]}, 32'd255);
    read_n(16);

    // destination stall for E3..E12
    load_all();
    max_cnt = 0;
    run(0, 2'b00, 8'd0, 2, 12, -1, lat);
    chk("lat_hold", lat, 32'd29);
    chk("fifo_bound", {31'd0, max_cnt <= 4}, 32'd1);
    read_n(16);

    // protocol errors during RUN
    load_all();
    run(0, 2'b00, 8'd0, -1, -1, 3, lat);
    chk("lat_err", lat, 32'd19);
    read_n(16);
    chk("err_sticky", {31'd0, err}, 32'd1);

    // reset at E6 of a 16-word transfer
    load_all();
    start = 1'b1; len = 0; mode = 0;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    chk("mid_rst_load_full", {31'd0, load_full}, 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (30) begin tick(); if (done) seen = 1; end
    chk("no_done_after_rst", seen, 32'd0);
    last_len_m = 16; ptr_m = 0;
    for (int i = 0; i < 16; i++) pat[i] = 8'(i * 9 + 3);
    load_all();
    run(3, 2'b11, 8'd250, -1, -1, -1, lat);
    chk("lat_post_rst", lat, 32'd6);
    read_n(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Single-clock, parametrised successor to the feature-to-weight memory transfer path. A source buffer is loaded word-by-word; a start pulse copies `len` words through an internal backpressured FIFO into a destination buffer, optionally reversed and/or bias-added with saturation. The destination buffer is then read out sequentially. It sits between the feature loader and the weight/compute memories.

## Interface
- `DATA_W`, 8, word width.
- `DEPTH`, 16, words in each of the source and destination memories (power of two, ≥2); `ADDR_W = $clog2(DEPTH)`.
- `FIFO_DEPTH`, 4, internal FIFO entries (power of two, ≥2).

- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  load `wr_data` into the source memory.
- `wr_data`  in  DATA_W  source word.
- `start`  in  1  begin a transfer; sampled only in IDLE.
- `len`  in  ADDR_W+1  word count, sampled with `start`; 0 or any value >DEPTH means DEPTH.
- `mode`  in  2  bit0 = reverse order; bit1 = add `bias`; sampled with `start`.
- `bias`  in  DATA_W  addend, sampled with `start`.
- `hold`  in  1  destination-side stall; no FIFO pop while high.
- `rd_en`  in  1  read next destination word.
- `rd_data`  out  DATA_W  registered destination word.
- `rd_valid`  out  1  `rd_data` valid this cycle.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.
- `load_full`  out  1  source write pointer has reached DEPTH.
- `err`  out  1  sticky protocol error.

## Operation
- Load: in IDLE, `wr_en` writes `src[wr_ptr]` and increments `wr_ptr`. At `wr_ptr == DEPTH`, `load_full = 1` and further writes are dropped without error. `wr_ptr` clears to 0 on `done`.
- FSM states: IDLE → RUN on `start` → FLUSH once all `len` reads have been issued → DONE once the FIFO is empty and nothing is in flight → IDLE after one cycle. `busy = 1` in RUN, FLUSH and DONE. `done = 1` only in DONE.
- Read side, RUN only: issues source read index `k = 0..len-1`. The address is `k`, or `len-1-k` when `mode[0]` is set. A read issues only while FIFO count plus in-flight reads is less than FIFO_DEPTH. Source read data is registered, then pushed into the FIFO on the next edge.
- Write side: when the FIFO is non-empty and `hold = 0`, pop one word and write it to `dst[j]`, with `j` incrementing from 0. Written value is the word itself, or `min(word + bias, 2^DATA_W - 1)` when `mode[1]` is set; the sum is computed DATA_W+1 wide. Push and pop in the same cycle are allowed and leave the count unchanged.
- Readout: when `busy = 0`, `rd_en` loads `rd_data <= dst[rd_ptr]` with `rd_valid = 1` on the next cycle. `rd_ptr` wraps to 0 after `last_len - 1`, where `last_len` is the length of the last completed transfer (DEPTH after reset). `rd_ptr` clears on `start`. When `busy = 1`, `rd_en` is ignored and `rd_valid = 0`.
- Errors: `start` while busy, or `wr_en` while busy, is ignored and sets `err`. `err` clears only on `rst`.
- Memory arrays are not reset. Unwritten source words transfer as undefined values.

## Timing
- Reset values: `rd_data = 0`, `rd_valid = 0`, `busy = 0`, `done = 0`, `load_full = 0`, `err = 0`. Also `wr_ptr = rd_ptr = 0`, FIFO empty, FSM in IDLE, `last_len = DEPTH`.
- Take `start` sampled at edge E0 with `hold = 0` throughout:
  - read k issues at E(k+1);
  - push at E(k+2);
  - pop and destination write at E(k+3);
  - `done` is high for the cycle after E(N+3);
  - `busy` rises after E0 and falls after E(N+4).
- Sustained throughput is one word per cycle.
- Each cycle with `hold = 1` delays completion by one cycle. The FIFO never overflows, and the read side stalls within FIFO_DEPTH cycles.
- `rst` mid-transfer: on the next edge the FSM goes to IDLE, the FIFO and in-flight state are cleared, `done` is not pulsed, and destination contents are partial.
- `start` and `wr_en` together in IDLE: the write is dropped, the transfer starts, and `err` is set.

## Test plan
- Load 4,14,24,42,141,243,41,134,204,124,104,24,34,74,84,95; `start` with `len = 0`, `mode = 00` → `done` after E19; `load_full = 1` before start; readout returns the same 16 values in order, then wraps to 4.
- Same load, `len = 5`, `mode = 01` → destination words 0..4 = 141,42,24,14,4; `done` after E8; readout wraps after 5 words.
- `mode = 10`, `bias = 20` → 243 becomes 255 (saturated), 4 becomes 24, 141 becomes 161.
- `hold = 1` for E3..E12 during a 16-word transfer → the read side stalls with FIFO count ≤ 4, no data is lost or duplicated, and `done` is delayed by 10 cycles.
- `start` and `wr_en` pulsed during RUN → both ignored, `err = 1` and stays 1; `rd_en` during busy → `rd_valid = 0`.
- `rst` at E6 of a 16-word transfer → next cycle `busy = 0`, `done` never pulses, `err = 0`; a new load and transfer then complete correctly.
